// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, presents it to inst_memory and
// captures the returned word into the IF/ID register. Handles stall,
// branch/jump redirect with flush, and stops fetching on HALT.
module fetch_stage #(
  parameter int unsigned                  PC_WIDTH    = 16,
  parameter int unsigned                  INSTR_WIDTH = 16,
  parameter int unsigned                  PC_STEP     = 4,
  parameter logic [PC_WIDTH-1:0]          RESET_PC    = 16'h0000,
  parameter logic [INSTR_WIDTH-1:0]       HALT_INSTR  = 16'hFFFF,
  parameter logic [INSTR_WIDTH-1:0]       NOP_INSTR   = 16'h0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic                   jump,
  input  logic [PC_WIDTH-1:0]    jump_target,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] ifid_instr,
  output logic [PC_WIDTH-1:0]    ifid_pc,
  output logic [PC_WIDTH-1:0]    ifid_pc_next,
  output logic                   ifid_valid,
  output logic                   halted
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic [PC_WIDTH-1:0]    ifid_pc_q, ifid_pc_d;
  logic [PC_WIDTH-1:0]    ifid_pc_next_q, ifid_pc_next_d;
  logic                   ifid_valid_q, ifid_valid_d;

  logic                   redirect;
  logic [PC_WIDTH-1:0]    redirect_raw;
  logic [PC_WIDTH-1:0]    redirect_pc;
  logic [PC_WIDTH-1:0]    pc_plus_step;

  // Redirect target selection (branch is older than jump) and sequential PC
  always_comb begin
    redirect     = branch_taken | jump;
    redirect_raw = branch_taken ? branch_target : jump_target;
    redirect_pc  = {redirect_raw[PC_WIDTH-1:2], 2'b00};
    pc_plus_step = pc_q + PC_WIDTH'(PC_STEP);
  end

  // Next-state logic: redirect > stall > sequential in RUN; HALT emits bubbles
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    ifid_instr_d   = ifid_instr_q;
    ifid_pc_d      = ifid_pc_q;
    ifid_pc_next_d = ifid_pc_next_q;
    ifid_valid_d   = ifid_valid_q;

    unique case (state_q)
      ST_RUN: begin
        if (redirect) begin
          pc_d         = redirect_pc;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end else if (!stall) begin
          ifid_instr_d   = imem_data;
          ifid_pc_d      = pc_q;
          ifid_pc_next_d = pc_plus_step;
          ifid_valid_d   = 1'b1;
          if (imem_data == HALT_INSTR) begin
            state_d = ST_HALT;
          end else begin
            pc_d = pc_plus_step;
          end
        end
      end
      ST_HALT: begin
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_RUN;
      pc_q           <= RESET_PC;
      ifid_instr_q   <= NOP_INSTR;
      ifid_pc_q      <= '0;
      ifid_pc_next_q <= '0;
      ifid_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      ifid_instr_q   <= ifid_instr_d;
      ifid_pc_q      <= ifid_pc_d;
      ifid_pc_next_q <= ifid_pc_next_d;
      ifid_valid_q   <= ifid_valid_d;
    end
  end

  assign imem_addr    = pc_q;
  assign ifid_instr   = ifid_instr_q;
  assign ifid_pc      = ifid_pc_q;
  assign ifid_pc_next = ifid_pc_next_q;
  assign ifid_valid   = ifid_valid_q;
  assign halted       = (state_q == ST_HALT);

endmodule
